if_fetch_redirect: RTL and testbench
====================================

// Module: if_fetch_redirect
// PURPOSE
//  Fetch-side consumer of the WB exception/ERET redirect (exc_bus) and the ID branch redirect.
//  Owns the fetch PC, drives the SRAM-like instruction request (req/addr_ok/data_ok) and hands
//  fetched words to ID. Squashes responses of requests made stale by a redirect, so WB never sees
//  a wrong-path instruction. Sits between the instruction bus and the IF/ID pipeline register.
// PARAMETERS
//  RESET_PC    32'hbfc00000  fetch PC after reset
//  NOP_INST    32'h00000000  word delivered for a misaligned PC (no bus request made)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  resetn        in   1   reset, asynchronous, active-low
//  exc_bus       in   33  {exc_valid, exc_pc}; WB holds exc_valid high until inst_addr_ok
//  jbr_bus       in   33  {jbr_taken, jbr_target}; one-cycle pulse from ID
//  IF_allow_in   in   1   ID accepts the word offered this cycle
//  inst_req      out  1   instruction request
//  inst_addr     out  32  request address (= fetch PC)
//  inst_addr_ok  in   1   request accepted this cycle
//  inst_data_ok  in   1   read data valid this cycle
//  inst_rdata    in   32  read data
//  IF_valid      out  1   word offered to ID
//  IF_over       out  1   IF_valid & IF_allow_in (handoff this cycle)
//  IF_inst       out  32  offered instruction word
//  IF_pc         out  32  PC of offered word
// BEHAVIOUR
//  Reset: state=S_REQ, fetch_pc=RESET_PC, pend_v=0, discard=0, IF_valid=0, IF_inst=0, IF_pc=0,
//   inst_req=0 during reset, 1 on first cycle after deassertion.
//  Redirect: redir = exc_valid | jbr_taken; target = exc_valid ? exc_pc : jbr_target (exc wins).
//  Sequential next PC = fetch_pc + 4, modulo 2^32 (0xfffffffc -> 0x00000000).
//  One outstanding request max. inst_req/inst_addr held stable from assertion until addr_ok.
//  S_REQ: inst_req=1 if fetch_pc[1:0]==0.
//   addr_ok: req_pc<=fetch_pc; ->S_WAIT; fetch_pc<=redir?target : pend_v?pend_pc : fetch_pc+4;
//    discard<=redir|pend_v; pend_v<=0.
//   redir w/o addr_ok: pend_v<=1, pend_pc<=target (later redirect overwrites); addr unchanged.
//   fetch_pc[1:0]!=0: no request; ->S_HOLD with IF_inst=NOP_INST, IF_pc=fetch_pc (WB raises AdEL).
//  S_WAIT: inst_req=0. redir: discard<=1, fetch_pc<=target.
//   data_ok & (discard|redir): drop word, discard<=0, ->S_REQ.
//   data_ok otherwise: IF_inst<=inst_rdata, IF_pc<=req_pc, ->S_HOLD.
//  S_HOLD: IF_valid=1. IF_allow_in: ->S_REQ. redir: IF_valid drops next cycle, fetch_pc<=target,
//   ->S_REQ (redir same cycle as IF_allow_in: handoff happens, redirect still taken).
//  Fetch latency: addr_ok->data_ok->IF_valid next cycle; back-to-back throughput 1 word / 3 cycles min.
//  exc_valid held several cycles: re-applied each cycle, idempotent; clears once addr_ok seen.
//  Async reset mid-request: state dropped; a data_ok after reset with no issued request is ignored
//   (S_REQ ignores data_ok).
// STRUCTURE
//  Shared package/defines: EXC_ENTER_ADDR, RESET_PC, bus widths (EXC_BUS_W=33, JBR_BUS_W=33),
//   state encodings S_REQ/S_WAIT/S_HOLD.
//  Single module; no sub-module (redirect mux + 3-state FSM + PC/pend/discard regs).
// TESTING
//  Reset release, addr_ok/data_ok 1 cycle each -> addr 0xbfc00000,0xbfc00004,... in order, IF_pc matches.
//  exc_bus={1,0xbfc00380} while in S_WAIT for 0xbfc00008 -> that word dropped, next addr 0xbfc00380.
//  jbr 0x80001000 and exc same cycle -> fetch goes to exc_pc, jbr ignored.
//  redir 0x80000010 while inst_req high, addr_ok 3 cycles later -> addr held, resp dropped, next 0x80000010.
//  jbr_target 0x80000002 -> no inst_req; IF_valid=1, IF_inst=0, IF_pc=0x80000002.
//  IF_allow_in low 4 cycles in S_HOLD -> IF_inst/IF_pc stable, no new request issued.

Source files
------------

// File: rtl/if_fetch_redirect_pkg.sv
`default_nettype none
// ============================================================================
// Package     : if_fetch_redirect_pkg
// Description : Shared constants, bus widths and FSM state encoding for the
//               fetch-stage redirect consumer.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_redirect_pkg;

    // Redirect bus widths: {valid/taken, 32-bit pc}
    localparam int EXC_BUS_W = 33;
    localparam int JBR_BUS_W = 33;

    // Architectural addresses
    localparam logic [31:0] EXC_ENTER_ADDR = 32'hbfc0_0380;
    localparam logic [31:0] DEF_RESET_PC   = 32'hbfc0_0000;

    // Fetch FSM: issue request, wait for data, hold word for ID
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_redirect
// Description : Fetch stage. Owns the fetch PC, issues one SRAM-like
//               instruction request at a time, applies exception/ERET and
//               branch redirects, and squashes responses made stale by a
//               redirect before they reach ID.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_redirect
    import if_fetch_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [EXC_BUS_W-1:0] exc_bus,
    input  logic [JBR_BUS_W-1:0] jbr_bus,
    input  logic                 IF_allow_in,
    output logic                 inst_req,
    output logic [31:0]          inst_addr,
    input  logic                 inst_addr_ok,
    input  logic                 inst_data_ok,
    input  logic [31:0]          inst_rdata,
    output logic                 IF_valid,
    output logic                 IF_over,
    output logic [31:0]          IF_inst,
    output logic [31:0]          IF_pc
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_fetch_pc, w_fetch_pc_nxt;
    logic         r_pend_v,   w_pend_v_nxt;
    logic [31:0]  r_pend_pc,  w_pend_pc_nxt;
    logic         r_discard,  w_discard_nxt;
    logic [31:0]  r_req_pc,   w_req_pc_nxt;
    logic [31:0]  r_if_inst,  w_if_inst_nxt;
    logic [31:0]  r_if_pc,    w_if_pc_nxt;

    logic         w_exc_valid, w_jbr_taken, w_redir, w_pc_aligned;
    logic [31:0]  w_exc_pc, w_jbr_target, w_target, w_seq_pc;

    // Redirect mux: exception/ERET has priority over a branch from ID
    assign w_exc_valid  = exc_bus[32];
    assign w_exc_pc     = exc_bus[31:0];
    assign w_jbr_taken  = jbr_bus[32];
    assign w_jbr_target = jbr_bus[31:0];
    assign w_redir      = w_exc_valid | w_jbr_taken;
    assign w_target     = w_exc_valid ? w_exc_pc : w_jbr_target;
    assign w_seq_pc     = r_fetch_pc + 32'd4;
    assign w_pc_aligned = (r_fetch_pc[1:0] == 2'b00);

    // Request is gated by reset so nothing is issued while resetn is low
    assign inst_req  = resetn && (r_state == S_REQ) && w_pc_aligned;
    assign inst_addr = r_fetch_pc;
    assign IF_valid  = (r_state == S_HOLD);
    assign IF_over   = IF_valid & IF_allow_in;
    assign IF_inst   = r_if_inst;
    assign IF_pc     = r_if_pc;

    // Next-state and next-register values for the fetch FSM
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_pend_v_nxt   = r_pend_v;
        w_pend_pc_nxt  = r_pend_pc;
        w_discard_nxt  = r_discard;
        w_req_pc_nxt   = r_req_pc;
        w_if_inst_nxt  = r_if_inst;
        w_if_pc_nxt    = r_if_pc;
        case (r_state)
            S_REQ: begin
                if (!w_pc_aligned) begin
                    // Misaligned PC: no bus access, hand ID a NOP tagged with
                    // the bad PC so WB can raise AdEL. A redirect that arrives
                    // now makes that NOP wrong-path, so follow it instead.
                    if (w_redir) begin
                        w_fetch_pc_nxt = w_target;
                    end else begin
                        w_state_nxt   = S_HOLD;
                        w_if_inst_nxt = NOP_INST;
                        w_if_pc_nxt   = r_fetch_pc;
                    end
                end else if (inst_addr_ok) begin
                    w_req_pc_nxt  = r_fetch_pc;
                    w_state_nxt   = S_WAIT;
                    w_discard_nxt = w_redir | r_pend_v;
                    w_pend_v_nxt  = 1'b0;
                    if (w_redir)
                        w_fetch_pc_nxt = w_target;
                    else if (r_pend_v)
                        w_fetch_pc_nxt = r_pend_pc;
                    else
                        w_fetch_pc_nxt = w_seq_pc;
                end else if (w_redir) begin
                    // Address must stay stable until accepted; remember the
                    // redirect and apply it once this request goes out.
                    w_pend_v_nxt  = 1'b1;
                    w_pend_pc_nxt = w_target;
                end
            end
            S_WAIT: begin
                if (w_redir) begin
                    w_discard_nxt  = 1'b1;
                    w_fetch_pc_nxt = w_target;
                end
                if (inst_data_ok) begin
                    if (r_discard || w_redir) begin
                        // Stale response: drop it, nothing left outstanding
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_REQ;
                    end else begin
                        w_if_inst_nxt = inst_rdata;
                        w_if_pc_nxt   = r_req_pc;
                        w_state_nxt   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_redir) begin
                    w_fetch_pc_nxt = w_target;
                    w_state_nxt    = S_REQ;
                end else if (IF_allow_in) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_pend_v   <= 1'b0;
            r_pend_pc  <= 32'h0;
            r_discard  <= 1'b0;
            r_req_pc   <= 32'h0;
            r_if_inst  <= 32'h0;
            r_if_pc    <= 32'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_pend_v   <= w_pend_v_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_discard  <= w_discard_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_if_inst  <= w_if_inst_nxt;
            r_if_pc    <= w_if_pc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_redirect
// Description : Self-checking bench for if_fetch_redirect. A small bus model
//               answers requests; expected (pc, word) pairs are queued when
//               the stimulus is applied and compared at each handoff to ID.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_redirect;
    import if_fetch_redirect_pkg::*;

    logic        clk;
    logic        resetn;
    logic [32:0] exc_bus;
    logic [32:0] jbr_bus;
    logic        IF_allow_in;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        IF_valid;
    logic        IF_over;
    logic [31:0] IF_inst;
    logic [31:0] IF_pc;

    int          n_vectors     = 0;
    int          n_miscompares = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];

    // Bus model state
    bit          bus_have, req_seen, last_acc, spurious;
    logic [31:0] bus_addr, hold_addr, last_addr;
    int          wait_cnt, addr_delay;

    logic [31:0] a;

    if_fetch_redirect u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .exc_bus      (exc_bus),
        .jbr_bus      (jbr_bus),
        .IF_allow_in  (IF_allow_in),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .IF_valid     (IF_valid),
        .IF_over      (IF_over),
        .IF_inst      (IF_inst),
        .IF_pc        (IF_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return pc ^ 32'h5a5a_0f0f;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
        exp_pc_q.push_back(pc);
        exp_inst_q.push_back(inst);
    endtask

    // One clock: drive bus responses, score any handoff, advance past the edge
    task automatic step();
        logic [31:0] epc, einst;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        last_acc     = 1'b0;
        if (resetn) begin
            if (spurious) begin
                inst_data_ok = 1'b1;
                inst_rdata   = 32'hdead_beef;
                spurious     = 1'b0;
            end else if (bus_have) begin
                check_eq("one_outstanding", inst_req, 1'b0);
                inst_data_ok = 1'b1;
                inst_rdata   = word_of(bus_addr);
                bus_have     = 1'b0;
            end else if (inst_req) begin
                if (!req_seen) begin
                    req_seen  = 1'b1;
                    hold_addr = inst_addr;
                    wait_cnt  = 0;
                end else begin
                    check_eq("addr_hold", inst_addr, hold_addr);
                end
                if (wait_cnt >= addr_delay) begin
                    inst_addr_ok = 1'b1;
                    bus_addr     = inst_addr;
                    bus_have     = 1'b1;
                    last_acc     = 1'b1;
                    last_addr    = inst_addr;
                    req_seen     = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else if (req_seen) begin
                check_eq("req_held", inst_req, 1'b1);
            end
        end
        #1;
        if (IF_valid && IF_allow_in) begin
            check_eq("if_over", IF_over, 1'b1);
            check_eq("sb_nonempty", exp_pc_q.size() != 0, 1'b1);
            if (exp_pc_q.size() != 0) begin
                epc   = exp_pc_q.pop_front();
                einst = exp_inst_q.pop_front();
                check_eq("hand_pc", IF_pc, epc);
                check_eq("hand_inst", IF_inst, einst);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(output logic [31:0] addr);
        int n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) check_eq("acc_timeout", last_acc, 1'b1);
        addr = last_addr;
    endtask

    // WB keeps exc_valid up until it sees a request accepted
    task automatic hold_exc_until_acc(output logic [31:0] addr);
        wait_acc(addr);
        exc_bus = 33'h0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_pc_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check_eq("drain", exp_pc_q.size(), 0);
    endtask

    initial begin
        resetn       = 1'b0;
        exc_bus      = 33'h0;
        jbr_bus      = 33'h0;
        IF_allow_in  = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        bus_have     = 1'b0;
        req_seen     = 1'b0;
        last_acc     = 1'b0;
        spurious     = 1'b0;
        bus_addr     = 32'h0;
        hold_addr    = 32'h0;
        last_addr    = 32'h0;
        wait_cnt     = 0;
        addr_delay   = 0;

        // Reset state
        #2;
        check_eq("rst_req", inst_req, 1'b0);
        check_eq("rst_valid", IF_valid, 1'b0);
        check_eq("rst_inst", IF_inst, 32'h0);
        check_eq("rst_pc", IF_pc, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        check_eq("post_rst_req", inst_req, 1'b1);
        check_eq("post_rst_addr", inst_addr, 32'hbfc0_0000);

        // Sequential fetch in order
        IF_allow_in = 1'b1;
        push_exp(32'hbfc0_0000, word_of(32'hbfc0_0000));
        push_exp(32'hbfc0_0004, word_of(32'hbfc0_0004));
        for (int i = 0; i < 3; i++) begin
            wait_acc(a);
            check_eq("seq_addr", a, 32'hbfc0_0000 + 32'(4 * i));
        end
        check_eq("seq_drained", exp_pc_q.size(), 0);

        // Exception while waiting on 0xbfc00008: that word is dropped
        exc_bus = {1'b1, 32'hbfc0_0380};
        push_exp(32'hbfc0_0380, word_of(32'hbfc0_0380));
        hold_exc_until_acc(a);
        check_eq("exc_addr", a, 32'hbfc0_0380);
        drain();
        IF_allow_in = 1'b0;

        // Exception and branch in the same cycle: exception wins
        wait_acc(a);
        check_eq("pre_c_addr", a, 32'hbfc0_0384);
        exc_bus = {1'b1, 32'h8000_0200};
        jbr_bus = {1'b1, 32'h8000_1000};
        push_exp(32'h8000_0200, word_of(32'h8000_0200));
        step();
        jbr_bus = 33'h0;
        hold_exc_until_acc(a);
        check_eq("exc_over_jbr", a, 32'h8000_0200);
        IF_allow_in = 1'b1;
        drain();
        IF_allow_in = 1'b0;

        // Redirect while a request is held waiting for addr_ok
        addr_delay = 3;
        jbr_bus = {1'b1, 32'h8000_0010};
        push_exp(32'h8000_0010, word_of(32'h8000_0010));
        step();
        jbr_bus = 33'h0;
        wait_acc(a);
        check_eq("held_addr", a, 32'h8000_0204);
        addr_delay = 0;
        wait_acc(a);
        check_eq("pend_addr", a, 32'h8000_0010);
        IF_allow_in = 1'b1;
        drain();
        IF_allow_in = 1'b0;

        // Misaligned branch target: NOP with the bad PC, no request
        wait_acc(a);
        check_eq("pre_mis_addr", a, 32'h8000_0014);
        jbr_bus = {1'b1, 32'h8000_0002};
        step();
        jbr_bus = 33'h0;
        check_eq("mis_no_req", inst_req, 1'b0);
        step();
        check_eq("mis_valid", IF_valid, 1'b1);
        check_eq("mis_inst", IF_inst, 32'h0);
        check_eq("mis_pc", IF_pc, 32'h8000_0002);

        // Stall in hold: word stable, no new request
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("stall_pc", IF_pc, 32'h8000_0002);
            check_eq("stall_inst", IF_inst, 32'h0);
            check_eq("stall_req", inst_req, 1'b0);
            check_eq("stall_over", IF_over, 1'b0);
        end

        // Handoff and redirect in the same cycle
        push_exp(32'h8000_0002, 32'h0);
        push_exp(32'h8000_0100, word_of(32'h8000_0100));
        IF_allow_in = 1'b1;
        jbr_bus = {1'b1, 32'h8000_0100};
        step();
        jbr_bus = 33'h0;
        wait_acc(a);
        check_eq("hold_redir_addr", a, 32'h8000_0100);
        drain();
        IF_allow_in = 1'b0;

        // Redirect while holding with ID stalled drops the held word
        for (int n = 0; n < 10 && !IF_valid; n++) step();
        check_eq("held_pc", IF_pc, 32'h8000_0104);
        check_eq("held_inst", IF_inst, word_of(32'h8000_0104));
        jbr_bus = {1'b1, 32'h8000_0300};
        push_exp(32'h8000_0300, word_of(32'h8000_0300));
        step();
        jbr_bus = 33'h0;
        check_eq("drop_valid", IF_valid, 1'b0);
        check_eq("drop_req", inst_req, 1'b1);
        check_eq("drop_addr", inst_addr, 32'h8000_0300);
        IF_allow_in = 1'b1;
        drain();
        IF_allow_in = 1'b0;

        // Asynchronous reset with a request outstanding; stray data_ok after
        wait_acc(a);
        resetn   = 1'b0;
        bus_have = 1'b0;
        req_seen = 1'b0;
        #1;
        check_eq("arst_req", inst_req, 1'b0);
        check_eq("arst_valid", IF_valid, 1'b0);
        check_eq("arst_pc", IF_pc, 32'h0);
        check_eq("arst_addr", inst_addr, 32'hbfc0_0000);
        repeat (2) @(posedge clk);
        #1;
        resetn     = 1'b1;
        addr_delay = 2;
        spurious   = 1'b1;
        push_exp(32'hbfc0_0000, word_of(32'hbfc0_0000));
        IF_allow_in = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
